// File: rtl/detrans_if.sv
// -----------------------------------------------------------------------------
// detrans_if
// Bundles the handshake and data signals of the detransform controller.
//   slave  modport : seen by detrans_ctrl
//   master modport : seen by the environment driving/consuming the controller
// Signals
//   valid_i/diff_i/ready_o      : upstream residual block handshake
//   flush_i                     : synchronous abort of the in-flight block
//   det_data_o/det_result_i     : operand to / result from the detransformer
//   valid_o/data_o/ready_i      : downstream reconstructed block handshake
//   busy_o                      : controller is not idle
// -----------------------------------------------------------------------------
interface detrans_if #(
  parameter int DATA_W = 256
);
  logic              valid_i;
  logic [DATA_W-1:0] diff_i;
  logic              ready_o;
  logic              flush_i;
  logic [DATA_W-1:0] det_data_o;
  logic [DATA_W-1:0] det_result_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic              busy_o;

  modport slave (
    input  valid_i, diff_i, flush_i, det_result_i, ready_i,
    output ready_o, det_data_o, valid_o, data_o, busy_o
  );

  modport master (
    output valid_i, diff_i, flush_i, det_result_i, ready_i,
    input  ready_o, det_data_o, valid_o, data_o, busy_o
  );
endinterface

// File: rtl/detrans_ctrl.sv
// -----------------------------------------------------------------------------
// detrans_ctrl
// Sequences a residual block through an external combinational detransformer
// that is timed as a MC_CYCLES multicycle path. The operand register feeding
// that path is held stable for the whole computation; the result is captured
// in the last allotted cycle and presented with a valid/ready handshake.
// Parameters
//   MC_CYCLES : cycles allotted to the detransform path (1..15)
//   DATA_W    : block width in bits
// Ports
//   clk, rst  : single clock, asynchronous active-high reset
//   bus       : detrans_if.slave (upstream, datapath and downstream signals)
//   blk_cnt_o : completed output handshakes, present only when the macro
//               DETRANS_CTRL_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module detrans_ctrl #(
  parameter int MC_CYCLES = 2,
  parameter int DATA_W    = 256
) (
  input  logic        clk,
  input  logic        rst,
  detrans_if.slave    bus
`ifdef DETRANS_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] blk_cnt_o
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(MC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CALC = 3'b010,
    OUT  = 3'b100
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [DATA_W-1:0] det_data_r;
  logic [DATA_W-1:0] data_r;
  logic              ready_s;
  logic              accept_s;
  logic              out_hs_s;

  // Acceptance window: idle, or draining the output this cycle; flush vetoes.
  always_comb begin
    ready_s = 1'b0;
    if (bus.flush_i) begin
      ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      ready_s = 1'b1;
    end else if (state_r == OUT) begin
      ready_s = bus.ready_i;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s = bus.valid_i & ready_s;
  assign out_hs_s = (state_r == OUT) & bus.ready_i;

  // Controller FSM with operand/result registers and multicycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      det_data_r <= '0;
      data_r     <= '0;
    end else if (bus.flush_i) begin
      // Data registers keep their contents; only control is abandoned.
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            det_data_r <= bus.diff_i;
            cnt_r      <= CNT_LOAD;
            state_r    <= CALC;
          end
        end
        CALC: begin
          // det_data_r is untouched here so the multicycle source stays stable.
          if (cnt_r == 4'd0) begin
            data_r  <= bus.det_result_i;
            state_r <= OUT;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        OUT: begin
          if (accept_s) begin
            // Back-to-back: next block enters CALC without an IDLE bubble.
            det_data_r <= bus.diff_i;
            cnt_r      <= CNT_LOAD;
            state_r    <= CALC;
          end else if (bus.ready_i) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.ready_o    = ready_s;
  assign bus.det_data_o = det_data_r;
  assign bus.data_o     = data_r;
  assign bus.valid_o    = (state_r == OUT);
  assign bus.busy_o     = (state_r != IDLE);

`ifdef DETRANS_CTRL_PERF_CNT_EN
  logic [31:0] blk_cnt_r;

  // Completed output handshakes; flush does not touch it, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_r <= 32'd0;
    end else if (out_hs_s) begin
      blk_cnt_r <= blk_cnt_r + 32'd1;
    end
  end

  assign blk_cnt_o = blk_cnt_r;
`else
  logic unused_s;
  assign unused_s = out_hs_s;
`endif

endmodule
